// File: rtl/screen_coords_pkg.sv
// Shared game parameters for the screen-side and global-coordinate-side logic,
// plus the axis selector used by the single shared mm-to-pixel scaler.
package screen_coords_pkg;

   localparam int GAME_H_PIX   = 1024;
   localparam int GAME_V_PIX   = 768;
   localparam int GAME_SCALE_K = 6554;   // pixels per mm, Q16 fixed point
   localparam int MM_PER_M     = 1000;

   typedef enum logic {
      AXIS_X = 1'b0,
      AXIS_Y = 1'b1
   } axis_e;

endpackage

// File: rtl/screen_coords_mm_scale.sv
// Combinational mm-to-pixel conversion for one axis: origin offset, Q16 multiply,
// clamp, and y flip so that row 0 is the top of the screen.
module mm_scale
   import screen_coords_pkg::*;
#(
   parameter int SCALE_K     = GAME_SCALE_K,
   parameter int H_PIX       = GAME_H_PIX,
   parameter int V_PIX       = GAME_V_PIX,
   parameter int X_ORIGIN_MM = 0
) (
   input  logic [15:0] coord,
   input  axis_e       mode,
   output logic [10:0] pix_x,
   output logic [9:0]  pix_y,
   output logic        on_axis
);

   localparam logic [15:0] H_MAX = 16'(H_PIX - 1);
   localparam logic [15:0] V_MAX = 16'(V_PIX - 1);

   logic [16:0] rel;
   logic [15:0] operand;
   logic [31:0] prod;
   logic [15:0] p;

   // One multiplier serves both axes; rel[16] is the sign of the origin-relative x.
   always_comb begin
      rel     = {1'b0, coord} - 17'(X_ORIGIN_MM);
      operand = (mode == AXIS_Y) ? coord : rel[15:0];
      prod    = 32'(operand) * 32'(SCALE_K);
      p       = 16'(prod >> 16);
      pix_x   = '0;
      pix_y   = '0;
      on_axis = 1'b0;
      if (mode == AXIS_X) begin
         if (rel[16]) begin
            pix_x = '0;
         end else if (p > H_MAX) begin
            pix_x = 11'(H_MAX);
         end else begin
            pix_x   = 11'(p);
            on_axis = 1'b1;
         end
      end else begin
         if (p > V_MAX) begin
            pix_y = '0;
         end else begin
            pix_y   = 10'(V_MAX - p);
            on_axis = 1'b1;
         end
      end
   end

endmodule

// File: rtl/screen_coords.sv
// Converts two gloves' global mm coordinates to screen pixels, one axis per clock
// through a single shared scaler, and publishes all results together with a valid pulse.
module screen_coords
   import screen_coords_pkg::*;
#(
   parameter int SCALE_K     = GAME_SCALE_K,
   parameter int H_PIX       = GAME_H_PIX,
   parameter int V_PIX       = GAME_V_PIX,
   parameter int X_ORIGIN_MM = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] glob_glove1x,
   input  logic [15:0] glob_glove1y,
   input  logic [15:0] glob_glove2x,
   input  logic [15:0] glob_glove2y,
   output logic [10:0] pix_glove1x,
   output logic [9:0]  pix_glove1y,
   output logic [10:0] pix_glove2x,
   output logic [9:0]  pix_glove2y,
   output logic        onscreen1,
   output logic        onscreen2,
   output logic        busy,
   output logic        valid
);

   typedef enum logic [2:0] {IDLE, G1X, G1Y, G2X, G2Y, DONE} state_e;

   state_e      state_q, state_d;
   logic [15:0] snap_q  [4];
   logic [15:0] snap_d  [4];
   logic [10:0] res_x_q [2];
   logic [10:0] res_x_d [2];
   logic [9:0]  res_y_q [2];
   logic [9:0]  res_y_d [2];
   logic [3:0]  res_on_q, res_on_d;
   logic [10:0] pix1x_q, pix1x_d, pix2x_q, pix2x_d;
   logic [9:0]  pix1y_q, pix1y_d, pix2y_q, pix2y_d;
   logic        on1_q, on1_d, on2_q, on2_d;
   logic        valid_q, valid_d;

   logic [15:0] sc_coord;
   axis_e       sc_mode;
   logic [10:0] sc_pix_x;
   logic [9:0]  sc_pix_y;
   logic        sc_on;

   mm_scale #(
      .SCALE_K    (SCALE_K),
      .H_PIX      (H_PIX),
      .V_PIX      (V_PIX),
      .X_ORIGIN_MM(X_ORIGIN_MM)
   ) u_mm_scale (
      .coord  (sc_coord),
      .mode   (sc_mode),
      .pix_x  (sc_pix_x),
      .pix_y  (sc_pix_y),
      .on_axis(sc_on)
   );

   // Snapshot index order is g1x, g1y, g2x, g2y; the state picks what feeds the scaler.
   always_comb begin
      sc_coord = snap_q[0];
      sc_mode  = AXIS_X;
      case (state_q)
         G1Y:     begin sc_coord = snap_q[1]; sc_mode = AXIS_Y; end
         G2X:     begin sc_coord = snap_q[2]; sc_mode = AXIS_X; end
         G2Y:     begin sc_coord = snap_q[3]; sc_mode = AXIS_Y; end
         default: ;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      snap_d   = snap_q;
      res_x_d  = res_x_q;
      res_y_d  = res_y_q;
      res_on_d = res_on_q;
      pix1x_d  = pix1x_q;
      pix1y_d  = pix1y_q;
      pix2x_d  = pix2x_q;
      pix2y_d  = pix2y_q;
      on1_d    = on1_q;
      on2_d    = on2_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d   = G1X;
            snap_d[0] = glob_glove1x;
            snap_d[1] = glob_glove1y;
            snap_d[2] = glob_glove2x;
            snap_d[3] = glob_glove2y;
         end
         G1X:  begin state_d = G1Y;  res_x_d[0] = sc_pix_x; res_on_d[0] = sc_on; end
         G1Y:  begin state_d = G2X;  res_y_d[0] = sc_pix_y; res_on_d[1] = sc_on; end
         G2X:  begin state_d = G2Y;  res_x_d[1] = sc_pix_x; res_on_d[2] = sc_on; end
         G2Y:  begin state_d = DONE; res_y_d[1] = sc_pix_y; res_on_d[3] = sc_on; end
         DONE: begin
            state_d = IDLE;
            pix1x_d = res_x_q[0];
            pix1y_d = res_y_q[0];
            pix2x_d = res_x_q[1];
            pix2y_d = res_y_q[1];
            on1_d   = res_on_q[0] & res_on_q[1];
            on2_d   = res_on_q[2] & res_on_q[3];
            valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         snap_q   <= '{default: '0};
         res_x_q  <= '{default: '0};
         res_y_q  <= '{default: '0};
         res_on_q <= '0;
         pix1x_q  <= '0;
         pix1y_q  <= '0;
         pix2x_q  <= '0;
         pix2y_q  <= '0;
         on1_q    <= 1'b0;
         on2_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         snap_q   <= snap_d;
         res_x_q  <= res_x_d;
         res_y_q  <= res_y_d;
         res_on_q <= res_on_d;
         pix1x_q  <= pix1x_d;
         pix1y_q  <= pix1y_d;
         pix2x_q  <= pix2x_d;
         pix2y_q  <= pix2y_d;
         on1_q    <= on1_d;
         on2_q    <= on2_d;
         valid_q  <= valid_d;
      end
   end

   assign pix_glove1x = pix1x_q;
   assign pix_glove1y = pix1y_q;
   assign pix_glove2x = pix2x_q;
   assign pix_glove2y = pix2y_q;
   assign onscreen1   = on1_q;
   assign onscreen2   = on2_q;
   assign valid       = valid_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_screen_coords.sv
// Self-checking bench for screen_coords: two instances (x origin 0 and 1000) driven
// by directed and random glove positions, checked against an arithmetic model.
module tb_screen_coords;

   localparam int ORIGIN_B = 1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] g1x, g1y, g2x, g2y;

   logic [10:0] a1x, a2x, b1x, b2x;
   logic [9:0]  a1y, a2y, b1y, b2y;
   logic        aOn1, aOn2, bOn1, bOn2;
   logic        busyA, busyB, validA, validB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   screen_coords dutA (
      .clk(clk), .reset(reset), .start(start),
      .glob_glove1x(g1x), .glob_glove1y(g1y), .glob_glove2x(g2x), .glob_glove2y(g2y),
      .pix_glove1x(a1x), .pix_glove1y(a1y), .pix_glove2x(a2x), .pix_glove2y(a2y),
      .onscreen1(aOn1), .onscreen2(aOn2), .busy(busyA), .valid(validA)
   );

   screen_coords #(.X_ORIGIN_MM(ORIGIN_B)) dutB (
      .clk(clk), .reset(reset), .start(start),
      .glob_glove1x(g1x), .glob_glove1y(g1y), .glob_glove2x(g2x), .glob_glove2y(g2y),
      .pix_glove1x(b1x), .pix_glove1y(b1y), .pix_glove2x(b2x), .pix_glove2y(b2y),
      .onscreen1(bOn1), .onscreen2(bOn2), .busy(busyB), .valid(validB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference: pixels = floor(mm * 6554 / 65536), clamped to the 1024x768 screen.
   function automatic void modelX(input int glob, input int origin, output int pix, output bit on);
      longint rel, p;
      rel = longint'(glob) - longint'(origin);
      if (rel < 0) begin
         pix = 0; on = 0;
      end else begin
         p = (rel * 6554) / 65536;
         if (p > 1023) begin pix = 1023; on = 0; end
         else begin pix = int'(p); on = 1; end
      end
   endfunction

   function automatic void modelY(input int glob, output int pix, output bit on);
      longint p;
      p = (longint'(glob) * 6554) / 65536;
      if (p > 767) begin pix = 0; on = 0; end
      else begin pix = 767 - int'(p); on = 1; end
   endfunction

   task automatic checkAll(input string tag, input int c1x, input int c1y, input int c2x, input int c2y);
      int px1, py1, px2, py2;
      bit ox1, oy1, ox2, oy2;
      modelY(c1y, py1, oy1);
      modelY(c2y, py2, oy2);
      modelX(c1x, 0, px1, ox1);
      modelX(c2x, 0, px2, ox2);
      checkOutput({tag, ".a.pix1x"}, 32'(a1x), px1);
      checkOutput({tag, ".a.pix1y"}, 32'(a1y), py1);
      checkOutput({tag, ".a.pix2x"}, 32'(a2x), px2);
      checkOutput({tag, ".a.pix2y"}, 32'(a2y), py2);
      checkOutput({tag, ".a.on1"},   32'(aOn1), 32'(ox1 & oy1));
      checkOutput({tag, ".a.on2"},   32'(aOn2), 32'(ox2 & oy2));
      modelX(c1x, ORIGIN_B, px1, ox1);
      modelX(c2x, ORIGIN_B, px2, ox2);
      checkOutput({tag, ".b.pix1x"}, 32'(b1x), px1);
      checkOutput({tag, ".b.pix1y"}, 32'(b1y), py1);
      checkOutput({tag, ".b.pix2x"}, 32'(b2x), px2);
      checkOutput({tag, ".b.pix2y"}, 32'(b2y), py2);
      checkOutput({tag, ".b.on1"},   32'(bOn1), 32'(ox1 & oy1));
      checkOutput({tag, ".b.on2"},   32'(bOn2), 32'(ox2 & oy2));
   endtask

   // One conversion: inputs are scrambled right after the snapshot, and an optional
   // second start is pulsed while the first conversion is in G1Y.
   task automatic applyStimulus(input string tag, input int c1x, input int c1y, input int c2x,
                                input int c2y, input bit extraStart);
      int lat;
      int pulses;
      @(negedge clk);
      g1x = 16'(c1x); g1y = 16'(c1y); g2x = 16'(c2x); g2y = 16'(c2y);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      g1x = 16'($urandom); g1y = 16'($urandom); g2x = 16'($urandom); g2y = 16'($urandom);
      lat = 1;
      checkOutput({tag, ".busy"}, 32'(busyA), 1);
      for (int i = 2; i <= 12 && !validA; i++) begin
         @(negedge clk);
         lat   = i;
         start = (extraStart && i == 2);
      end
      start = 1'b0;
      checkOutput({tag, ".latency"}, lat, 6);
      checkOutput({tag, ".validB"}, 32'(validB), 32'(validA));
      checkOutput({tag, ".idle_busy"}, 32'(busyA), 0);
      checkAll(tag, c1x, c1y, c2x, c2y);
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (validA) pulses++;
      end
      checkOutput({tag, ".extra_valid"}, pulses, 0);
      checkAll({tag, ".hold"}, c1x, c1y, c2x, c2y);
   endtask

   initial begin
      int pulses;
      int hx, hy;
      reset = 1'b1; start = 1'b0;
      g1x = '0; g1y = '0; g2x = '0; g2y = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst.busy", 32'(busyA), 0);
      checkOutput("rst.valid", 32'(validA), 0);
      checkOutput("rst.pix", 32'({a1x, a1y}), 0);
      checkOutput("rst.on", 32'({aOn1, aOn2}), 0);
      reset = 1'b0;

      applyStimulus("basic", 2000, 2000, 8000, 2000, 1'b0);
      applyStimulus("clamp", 12000, 8000, 500, 3000, 1'b1);
      applyStimulus("zero", 0, 0, 0, 0, 1'b0);
      applyStimulus("edge_in", 10230, 7670, 1000, 7670, 1'b0);
      applyStimulus("edge_out", 10240, 7680, 999, 65535, 1'b1);
      applyStimulus("max", 65535, 65535, 65535, 1, 1'b0);
      for (int n = 0; n < 12; n++)
         applyStimulus("rand", int'($urandom_range(0, 13000)), int'($urandom_range(0, 9000)),
                       int'($urandom_range(0, 13000)), int'($urandom_range(0, 9000)),
                       1'($urandom_range(0, 1)));

      // Reset during G2X aborts the conversion and clears the outputs at once.
      @(negedge clk);
      g1x = 16'd3000; g1y = 16'd1000; g2x = 16'd4000; g2y = 16'd1500;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort.busy", 32'(busyA), 0);
      checkOutput("abort.valid", 32'(validA), 0);
      checkOutput("abort.pix", 32'({a1x, a1y, a2x}), 0);
      checkOutput("abort.pix2y", 32'(a2y), 0);
      checkOutput("abort.on", 32'({aOn1, aOn2, bOn1, bOn2}), 0);
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (validA || validB) pulses++;
      end
      checkOutput("abort.no_valid", pulses, 0);
      applyStimulus("after_rst", 5000, 2500, 700, 6000, 1'b0);

      // start held high: a conversion every 6 cycles, one idle cycle between them.
      @(negedge clk);
      hx = int'($urandom_range(0, 12000)); hy = int'($urandom_range(0, 8000));
      g1x = 16'(hx); g1y = 16'(hy); g2x = 16'(hy); g2y = 16'(hx);
      start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         checkOutput("b2b.valid", 32'(validA), 32'(i % 6 == 0));
         checkOutput("b2b.busy", 32'(busyA), 32'(i % 6 != 0));
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      checkAll("b2b", hx, hy, hy, hx);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/screen_coords.md
SCREEN_COORDS -- requirements
Module: screen_coords

Interface
REQ-001 Parameter SCALE_K, default 6554: pixels per mm times 65536 (about 10 mm per pixel).
REQ-002 Parameter H_PIX, default 1024: visible screen width in pixels.
REQ-003 Parameter V_PIX, default 768: visible screen height in pixels.
REQ-004 Parameter X_ORIGIN_MM, default 0: global x, in mm, that maps to screen column 0.
REQ-005 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port start, input, 1: request one conversion of the four glove coordinates.
REQ-008 Ports glob_glove1x, glob_glove1y, glob_glove2x, glob_glove2y, input, 16 each: global glove coordinates in mm, unsigned; y = 0 is ground.
REQ-009 Ports pix_glove1x, pix_glove2x, output, 11 each: screen column.
REQ-010 Ports pix_glove1y, pix_glove2y, output, 10 each: screen row; row 0 is the top of the screen.
REQ-011 Ports onscreen1, onscreen2, output, 1 each: the glove's x and y both fall inside the screen.
REQ-012 Port busy, input/output direction output, 1: a conversion is in progress.
REQ-013 Port valid, output, 1: one-cycle pulse when a new result set is on the outputs.

Function
REQ-014 The FSM SHALL have states IDLE, G1X, G1Y, G2X, G2Y and DONE.
REQ-015 Transition IDLE->G1X on start=1; on that edge all four glob_* inputs SHALL be snapshotted.
REQ-016 Transitions G1X->G1Y->G2X->G2Y->DONE->IDLE SHALL be unconditional, one per clock.
REQ-017 Each conversion state SHALL convert exactly one snapshotted coordinate through one shared scaler into an internal result register.
REQ-018 X conversion: rel = glob - X_ORIGIN_MM, computed signed at 17 bits.
  - rel < 0: column 0, axis off-screen.
  - otherwise p = (rel*SCALE_K)[31:16], using a 32-bit product.
  - p > H_PIX-1: column clamps to H_PIX-1, axis off-screen.
REQ-019 Y conversion: p = (glob*SCALE_K)[31:16].
  - p > V_PIX-1: row 0, axis off-screen.
  - otherwise row = V_PIX-1-p.
REQ-020 onscreenN SHALL be 1 only if both the x and y axes of glove N are on-screen.
REQ-021 In DONE, all pix_* and onscreen* outputs SHALL update together on one edge, and valid SHALL be high for exactly the following cycle.
REQ-022 Latency: start sampled at edge k gives valid high in the cycle after edge k+5.
REQ-023 Outputs SHALL hold their last values between valid pulses.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start while busy=1 SHALL be ignored; it is not queued.
REQ-026 Input changes after the snapshot SHALL NOT affect the conversion in progress.
REQ-027 start held high continuously SHALL produce back-to-back conversions, one every 6 cycles.

Reset
REQ-028 While reset=1, the FSM SHALL be forced to IDLE asynchronously.
REQ-029 Reset values: all pix_* = 0, onscreen* = 0, valid = 0, busy = 0, snapshot and result registers = 0.
REQ-030 Reset asserted mid-conversion SHALL abort the conversion with no valid pulse, and the outputs SHALL take their reset values.
REQ-031 After reset deasserts, the first start SHALL behave exactly as after power-up.

Structure
REQ-032 H_PIX, V_PIX, SCALE_K and the mm-per-metre constant SHALL live in the shared game-parameters include, which global_coords-side logic also uses.
REQ-033 The FSM state encodings SHALL be local to this module.
REQ-034 One sub-module, mm_scale, SHALL hold the combinational multiply, shift and clamp for one axis, selected by an x/y mode input.
REQ-035 Exactly one mm_scale instance SHALL exist, time-shared across the four conversion states.

Verification
REQ-036 Glove1 at (2000,2000) mm and glove2 at (8000,2000) mm, start pulse -> valid 6 cycles later; pix_glove1 = (200,567), pix_glove2 = (800,567), onscreen1 = onscreen2 = 1.
REQ-037 glob_glove1x = 12000, glob_glove1y = 8000 -> pix_glove1x = 1023, pix_glove1y = 0, onscreen1 = 0.
REQ-038 X_ORIGIN_MM = 1000 and glob_glove2x = 500 -> pix_glove2x = 0, onscreen2 = 0.
REQ-039 Second start pulse during G1Y, with inputs changed after the first start -> exactly one valid pulse, carrying the first snapshot's values.
REQ-040 Reset asserted during G2X -> busy = 0 and all outputs 0 immediately; no valid pulse follows; the next start converts correctly.
REQ-041 start held high for 20 cycles -> valid pulses at 6-cycle spacing, with busy low for exactly one cycle between conversions.
